cp_remover: RTL and testbench

// - Receive-chain stage directly upstream of the FFT wrapper in the OFDM PHY.
// - Takes the continuous time-domain sample stream (one complex sample per transfer) and counts

---
 rtl/ofdm_phy_pkg.sv | 24 ++
 rtl/wb_skid_buf.sv | 56 +++++
 rtl/cp_remover.sv | 158 +++++++++++++++
 tb/tb_cp_remover.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ofdm_phy_pkg.sv
// Purpose: shared constants and FSM encoding for the OFDM receive-chain stages.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ofdm_phy_pkg;

  // Default symbol geometry: 64-point FFT with a 16-sample cyclic prefix.
  localparam int NFFT_DEF  = 64;
  localparam int NCP_DEF   = 16;

  // Sample is {Im[31:16], Re[15:0]}, each 2.14 fixed point.
  localparam int SAMPLE_W  = 32;
  localparam int HALF_W    = SAMPLE_W / 2;

  // Width of the completed-symbol counter.
  localparam int SYM_CNT_W = 16;

  // Position of the cp_remover within the current OFDM block.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CP   = 2'd1,
    ST_DATA = 2'd2
  } cp_state_t;

endpackage

// File: rtl/wb_skid_buf.sv
// Purpose: 2-entry valid/ready skid buffer with fall-through when empty.
// Latency: 0 cycles when empty (input appears on pop side combinationally), else FIFO order.
// Backpressure: push_rdy depends only on occupancy (low when both entries hold data).
module wb_skid_buf #(
  parameter int DW = 32
) (
  input  logic          CLK_I,
  input  logic          RST_I,
  input  logic          push_vld,
  output logic          push_rdy,
  input  logic [DW-1:0] push_dat,
  output logic          pop_vld,
  input  logic          pop_rdy,
  output logic [DW-1:0] pop_dat
);

  logic [DW-1:0] mem [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    count;
  logic          push;
  logic          pop;
  logic          store;
  logic          drop_head;

  // Handshake decode; an empty buffer passes the input straight through so no cycle is lost.
  always_comb begin
    push_rdy  = (count != 2'd2);
    pop_vld   = (count != 2'd0) | push_vld;
    pop_dat   = (count != 2'd0) ? mem[rd_ptr] : push_dat;
    push      = push_vld & push_rdy;
    pop       = pop_vld & pop_rdy;
    // A sample that is consumed in the same cycle it arrives into an empty buffer is never stored.
    store     = push & ~((count == 2'd0) & pop);
    drop_head = pop & (count != 2'd0);
  end

  // Storage, pointers and occupancy; reset discards any held samples.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (store) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= ~wr_ptr;
      end
      if (drop_head) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, store} - {1'b0, drop_head};
    end
  end

endmodule

// File: rtl/cp_remover.sv
// Purpose: strips the cyclic prefix from each NCP+NFFT block and forwards the NFFT useful samples.
// Latency: 1 cycle from accepted input to STB_O when buffer and output register are empty.
// Backpressure: CP samples always acked; useful samples acked while the 2-entry skid buffer has room.
module cp_remover
  import ofdm_phy_pkg::*;
#(
  parameter int NFFT = NFFT_DEF,
  parameter int NCP  = NCP_DEF,
  parameter int DW   = SAMPLE_W
) (
  input  logic                 CLK_I,
  input  logic                 RST_I,
  input  logic [DW-1:0]        DAT_I,
  input  logic                 WE_I,
  input  logic                 STB_I,
  input  logic                 CYC_I,
  output logic                 ACK_O,
  output logic [DW-1:0]        DAT_O,
  output logic                 CYC_O,
  output logic                 STB_O,
  output logic                 WE_O,
  input  logic                 ACK_I,
  output logic [SYM_CNT_W-1:0] SYM_CNT
);

  localparam int            CW        = $clog2(NFFT);
  localparam logic [CW-1:0] CP_LAST   = CW'(NCP - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(NFFT - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [SYM_CNT_W-1:0] SYM_ONE = SYM_CNT_W'(1);

  cp_state_t             state;
  cp_state_t             state_nxt;
  logic [CW-1:0]         cnt;
  logic [CW-1:0]         cnt_nxt;
  logic [SYM_CNT_W-1:0]  sym_cnt_q;
  logic [SYM_CNT_W-1:0]  sym_nxt;
  logic                  req;
  logic                  ack;
  logic                  it;
  logic                  buf_push_vld;
  logic                  buf_push_rdy;
  logic                  buf_pop_vld;
  logic [DW-1:0]         buf_pop_dat;
  logic                  out_load;

  assign req          = CYC_I & STB_I & WE_I;
  assign buf_push_vld = (state == ST_DATA) & req;
  assign ACK_O        = ack & ~RST_I;
  assign WE_O         = STB_O;
  assign SYM_CNT      = sym_cnt_q;
  // The output register takes a new sample whenever it is empty or its current one is being taken.
  assign out_load     = ~STB_O | ACK_I;

  wb_skid_buf #(
    .DW(DW)
  ) u_skid (
    .CLK_I    (CLK_I),
    .RST_I    (RST_I),
    .push_vld (buf_push_vld),
    .push_rdy (buf_push_rdy),
    .push_dat (DAT_I),
    .pop_vld  (buf_pop_vld),
    .pop_rdy  (out_load),
    .pop_dat  (buf_pop_dat)
  );

  // Next-state, sample counter, symbol counter and input acknowledge.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sym_nxt   = sym_cnt_q;
    ack       = 1'b0;
    it        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (CYC_I) begin
          state_nxt = ST_CP;
          cnt_nxt   = '0;
          sym_nxt   = '0;
        end
      end
      ST_CP: begin
        // Prefix samples are discarded, so they never wait on the buffer.
        ack = 1'b1;
        it  = req;
        if (!CYC_I) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else if (it) begin
          if (cnt == CP_LAST) begin
            state_nxt = ST_DATA;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
      end
      ST_DATA: begin
        ack = buf_push_rdy;
        it  = req & buf_push_rdy;
        if (!CYC_I) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else if (it) begin
          if (cnt == DATA_LAST) begin
            state_nxt = ST_CP;
            cnt_nxt   = '0;
            sym_nxt   = sym_cnt_q + SYM_ONE;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // FSM, sample counter and symbol counter registers.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      sym_cnt_q <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      sym_cnt_q <= sym_nxt;
    end
  end

  // Output register and frame flag; DAT_O holds while a stalled sample waits for ACK_I.
  // CYC_O drops once the upstream frame has ended and the last sample has been handed over;
  // with CYC_I low the FSM is already heading to IDLE and no new sample can enter the buffer.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      STB_O <= 1'b0;
      DAT_O <= '0;
      CYC_O <= 1'b0;
    end else begin
      if (out_load) begin
        STB_O <= buf_pop_vld;
        if (buf_pop_vld) begin
          DAT_O <= buf_pop_dat;
        end
      end
      if (out_load & buf_pop_vld) begin
        CYC_O <= 1'b1;
      end else if (!CYC_I && out_load && !buf_pop_vld) begin
        CYC_O <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cp_remover.sv
// Purpose: scoreboard bench for cp_remover; stimulus pushes expected useful samples, a monitor pops them.
// Latency: n/a.
// Backpressure: ACK_I driven from a single process under forced-low / random control flags.
module tb_cp_remover;

  localparam int DW   = 32;
  localparam int NFFT = 64;
  localparam int NCP  = 16;
  localparam int BLK  = NFFT + NCP;

  logic          CLK_I = 1'b0;
  logic          RST_I;
  logic [DW-1:0] DAT_I;
  logic          WE_I;
  logic          STB_I;
  logic          CYC_I;
  logic          ACK_O;
  logic [DW-1:0] DAT_O;
  logic          CYC_O;
  logic          STB_O;
  logic          WE_O;
  logic          ACK_I;
  logic [15:0]   SYM_CNT;

  cp_remover #(.NFFT(NFFT), .NCP(NCP), .DW(DW)) dut (
    .CLK_I   (CLK_I),
    .RST_I   (RST_I),
    .DAT_I   (DAT_I),
    .WE_I    (WE_I),
    .STB_I   (STB_I),
    .CYC_I   (CYC_I),
    .ACK_O   (ACK_O),
    .DAT_O   (DAT_O),
    .CYC_O   (CYC_O),
    .STB_O   (STB_O),
    .WE_O    (WE_O),
    .ACK_I   (ACK_I),
    .SYM_CNT (SYM_CNT)
  );

  always #5 CLK_I = ~CLK_I;

  int          n_chk   = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];
  int          pos     = 0;
  int          exp_sym = 0;
  int          n_acc   = 0;
  int          ot_cnt  = 0;
  int          cyc     = 0;
  bit          ack_force_low = 1'b0;
  bit          ack_rand      = 1'b0;

  always @(posedge CLK_I) cyc <= cyc + 1;

  // FFT-side acceptance, updated 2 time units after each rising edge.
  initial begin
    ACK_I = 1'b1;
    forever begin
      @(posedge CLK_I);
      #2;
      ACK_I = ack_force_low ? 1'b0 : (ack_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Pops the expected sample for every output transfer.
  task automatic monitor();
    logic [31:0] e;
    forever begin
      @(negedge CLK_I);
      if (!RST_I && STB_O && ACK_I) begin
        ot_cnt++;
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL ot_unexpected: got %h, expected no output (queue empty)", DAT_O);
        end else begin
          e = exp_q.pop_front();
          chk("ot_data", DAT_O, e);
        end
      end
    end
  endtask

  // Presents one sample and returns one cycle after it was acknowledged; updates the CP-strip model.
  task automatic send(input logic [31:0] v);
    int g = 0;
    if (!CYC_I) begin
      exp_sym = 0;
      pos     = 0;
    end
    CYC_I = 1'b1;
    WE_I  = 1'b1;
    STB_I = 1'b1;
    DAT_I = v;
    while (!ACK_O && g < 200) begin
      @(posedge CLK_I);
      #1;
      g++;
    end
    if (g >= 200) begin
      n_chk++;
      n_fail++;
      $display("FAIL ack_timeout: ACK_O=%b after %0d cycles, expected 1", ACK_O, g);
      STB_I = 1'b0;
    end else begin
      if (pos >= NCP) exp_q.push_back(v);
      pos++;
      if (pos == BLK) begin
        pos = 0;
        exp_sym++;
      end
      n_acc++;
      @(posedge CLK_I);
      #1;
      STB_I = 1'b0;
    end
  endtask

  // Ends the frame and waits for all expected samples to leave the DUT.
  task automatic drain(input string nm);
    int g = 0;
    CYC_I = 1'b0;
    STB_I = 1'b0;
    pos   = 0;
    do begin
      @(negedge CLK_I);
      g++;
    end while ((STB_O || exp_q.size() != 0) && g < 500);
    if (g >= 500) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_drain_timeout: %0d samples still expected", nm, exp_q.size());
    end
    chk({nm, "_cyc_o"}, 32'(CYC_O), 32'd0);
  endtask

  initial begin
    int ot0;
    int acc0;
    int c0;
    RST_I = 1'b1;
    CYC_I = 1'b0;
    STB_I = 1'b0;
    WE_I  = 1'b0;
    DAT_I = '0;
    fork
      monitor();
      begin
        #400000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
      end
    join_none

    // Reset values.
    repeat (3) @(posedge CLK_I);
    #1;
    chk("rst_ack_o",   32'(ACK_O),   32'd0);
    chk("rst_stb_o",   32'(STB_O),   32'd0);
    chk("rst_cyc_o",   32'(CYC_O),   32'd0);
    chk("rst_we_o",    32'(WE_O),    32'd0);
    chk("rst_dat_o",   DAT_O,        32'd0);
    chk("rst_sym_cnt", 32'(SYM_CNT), 32'd0);
    RST_I = 1'b0;
    @(posedge CLK_I);
    #1;
    chk("idle_ack_o", 32'(ACK_O), 32'd0);

    // Two-block ramp with ACK_I high: 16..79 then 96..159.
    ot0 = ot_cnt;
    for (int i = 0; i < 2 * BLK; i++) begin
      send(32'(i));
      if (i == NCP) begin
        chk("lat_stb_o", 32'(STB_O), 32'd1);
        chk("lat_dat_o", DAT_O,      32'd16);
        chk("lat_cyc_o", 32'(CYC_O), 32'd1);
      end
    end
    drain("ramp");
    chk("ramp_ots",     32'(ot_cnt - ot0), 32'd128);
    chk("ramp_sym_cnt", 32'(SYM_CNT),      32'd2);

    // Five-cycle output stall after 10 useful samples.
    for (int i = 0; i < 26; i++) send(32'(i));
    acc0 = n_acc;
    ack_force_low = 1'b1;
    fork
      begin
        for (int i = 26; i < BLK; i++) send(32'(i));
      end
      begin
        chk("stall_head", DAT_O, 32'd25);
        repeat (5) begin
          @(negedge CLK_I);
          chk("stall_hold_dat", DAT_O,      32'd25);
          chk("stall_hold_stb", 32'(STB_O), 32'd1);
        end
        chk("stall_full_ack", 32'(ACK_O),         32'd0);
        chk("stall_accepts",  32'(n_acc - acc0),  32'd2);
        ack_force_low = 1'b0;
      end
    join
    drain("stall");
    chk("stall_sym_cnt", 32'(SYM_CNT), 32'd1);

    // ACK_I low throughout the prefix: 16 samples taken in 16 cycles after the IDLE cycle.
    ack_force_low = 1'b1;
    c0 = cyc;
    for (int i = 0; i < NCP; i++) send(32'h0100_0000 + 32'(i));
    chk("cp_cycles", 32'(cyc - c0), 32'd17);
    chk("cp_no_stb", 32'(STB_O),    32'd0);
    ack_force_low = 1'b0;
    for (int i = NCP; i < BLK; i++) send(32'h0100_0000 + 32'(i));
    drain("cpstall");
    chk("cpstall_sym_cnt", 32'(SYM_CNT), 32'd1);

    // Frame ends 40 samples into a block: 24 useful samples.
    ot0 = ot_cnt;
    for (int i = 0; i < 40; i++) send(32'h0200_0000 + 32'(i));
    drain("partial");
    chk("partial_ots",     32'(ot_cnt - ot0), 32'd24);
    chk("partial_sym_cnt", 32'(SYM_CNT),      32'd0);
    ot0 = ot_cnt;
    for (int i = 0; i < BLK; i++) send(32'h0300_0000 + 32'(i));
    drain("restart");
    chk("restart_ots",     32'(ot_cnt - ot0), 32'd64);
    chk("restart_sym_cnt", 32'(SYM_CNT),      32'd1);

    // Reset with one sample in the output register and two in the buffer.
    for (int i = 0; i < NCP; i++) send(32'h0400_0000 + 32'(i));
    ack_force_low = 1'b1;
    for (int i = NCP; i < NCP + 3; i++) send(32'h0400_0000 + 32'(i));
    chk("prerst_ack_full", 32'(ACK_O), 32'd0);
    chk("prerst_stb_o",    32'(STB_O), 32'd1);
    RST_I = 1'b1;
    CYC_I = 1'b0;
    STB_I = 1'b0;
    exp_q.delete();
    pos = 0;
    @(posedge CLK_I);
    #1;
    chk("midrst_ack_o",   32'(ACK_O),   32'd0);
    chk("midrst_stb_o",   32'(STB_O),   32'd0);
    chk("midrst_cyc_o",   32'(CYC_O),   32'd0);
    chk("midrst_we_o",    32'(WE_O),    32'd0);
    chk("midrst_dat_o",   DAT_O,        32'd0);
    chk("midrst_sym_cnt", 32'(SYM_CNT), 32'd0);
    RST_I = 1'b0;
    ack_force_low = 1'b0;

    // Twenty blocks with random input gaps and random FFT back-pressure.
    ack_rand = 1'b1;
    ot0 = ot_cnt;
    for (int s = 0; s < 20; s++) begin
      for (int k = 0; k < BLK; k++) begin
        send(32'h5A5A_0000 ^ 32'(s * BLK + k));
        if ($urandom_range(0, 3) == 0) begin
          repeat ($urandom_range(1, 3)) begin
            @(posedge CLK_I);
            #1;
          end
        end
      end
    end
    drain("rand");
    chk("rand_ots",     32'(ot_cnt - ot0), 32'd1280);
    chk("rand_sym_cnt", 32'(SYM_CNT),      32'd20);
    chk("rand_model_sym", 32'(SYM_CNT),    32'(exp_sym));
    ack_rand = 1'b0;

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
